// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared FSM type and default sizing for the 2:1 Avalon arbiter
package avalon_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t;
    localparam int ARB_DATA_W = 32;
    localparam int BE_W = ARB_DATA_W / 8;
endpackage

// File: rtl/avalon_master_mux.sv
// avalon_master_mux: steers the owning master's command onto the slave port
module avalon_master_mux
    import avalon_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic [1:0]          grant,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable
);
    // Owner's command passes straight through; an idle bus presents all zeros
    always_comb begin
        s_address    = grant[1] ? m1_address    : grant[0] ? m0_address    : '0;
        s_read       = grant[1] ? m1_read       : grant[0] ? m0_read       : 1'b0;
        s_write      = grant[1] ? m1_write      : grant[0] ? m0_write      : 1'b0;
        s_writedata  = grant[1] ? m1_writedata  : grant[0] ? m0_writedata  : '0;
        s_byteenable = grant[1] ? m1_byteenable : grant[0] ? m0_byteenable : '0;
    end
endmodule

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: round-robin, transaction-locked 2:1 Avalon-MM arbiter with stall watchdog
module avalon_bus_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant,
    output logic                bus_error
);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q;
    logic          last_q;
    logic [CW-1:0] stall_cnt_q;
    logic          bus_error_q;
    logic          req0, req1, own_n, own_req, other_req;

    // Request decode and state-derived steering; the non-owner is always stalled
    always_comb begin
        req0           = m0_read | m0_write;
        req1           = m1_read | m1_write;
        own_n          = state_q == ARB_GRANT1;
        own_req        = own_n ? req1 : req0;
        other_req      = own_n ? req0 : req1;
        grant          = {state_q == ARB_GRANT1, state_q == ARB_GRANT0};
        m0_waitrequest = state_q == ARB_GRANT0 ? s_waitrequest : 1'b1;
        m1_waitrequest = state_q == ARB_GRANT1 ? s_waitrequest : 1'b1;
        m0_readdata    = s_readdata;
        m1_readdata    = s_readdata;
        bus_error      = bus_error_q;
    end

    avalon_master_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .grant         (grant),
        .m0_address    (m0_address),
        .m0_read       (m0_read),
        .m0_write      (m0_write),
        .m0_writedata  (m0_writedata),
        .m0_byteenable (m0_byteenable),
        .m1_address    (m1_address),
        .m1_read       (m1_read),
        .m1_write      (m1_write),
        .m1_writedata  (m1_writedata),
        .m1_byteenable (m1_byteenable),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_byteenable  (s_byteenable)
    );

    // Arbitration FSM: hand over directly on completion, abort a stalled owner at TIMEOUT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            last_q      <= 1'b1;
            stall_cnt_q <= '0;
            bus_error_q <= 1'b0;
        end else if (state_q == ARB_IDLE) begin
            stall_cnt_q <= '0;
            state_q     <= (req0 && (!req1 || last_q)) ? ARB_GRANT0 : req1 ? ARB_GRANT1 : ARB_IDLE;
        end else if (!own_req) begin
            stall_cnt_q <= '0;
            state_q     <= ARB_IDLE;
        end else if (!s_waitrequest) begin
            stall_cnt_q <= '0;
            last_q      <= own_n;
            state_q     <= other_req ? (own_n ? ARB_GRANT0 : ARB_GRANT1) : state_q;
        end else if (stall_cnt_q == CW'(TIMEOUT - 1)) begin
            stall_cnt_q <= CW'(TIMEOUT);
            bus_error_q <= 1'b1;
            last_q      <= own_n;
            state_q     <= ARB_IDLE;
        end else begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Master protocol violations are only flagged in simulation, never acted upon
    assert property (@(posedge clk) !reset |-> !(m0_read && m0_write));
    assert property (@(posedge clk) !reset |-> !(m1_read && m1_write));
    assert property (@(posedge clk) (!reset && state_q == ARB_GRANT0 && req0 && s_waitrequest
                     && stall_cnt_q != CW'(TIMEOUT - 1)) |=> (reset || req0));
    assert property (@(posedge clk) (!reset && state_q == ARB_GRANT1 && req1 && s_waitrequest
                     && stall_cnt_q != CW'(TIMEOUT - 1)) |=> (reset || req1));
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb_avalon_bus_arbiter: directed checks of the 2:1 arbiter against a one-wait-state RAM model
module tb_avalon_bus_arbiter;
    import avalon_arb_pkg::*;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [BE_W-1:0] m0_byteenable = '1, m1_byteenable = '1;
    logic m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic s_read, s_write, s_waitrequest;
    logic [BE_W-1:0] s_byteenable;
    logic [1:0] grant;
    logic bus_error;

    logic stall_force = 1'b0;
    logic ready_q;
    logic [31:0] mem [256];
    logic acc;
    logic [7:0] idx;

    int checks = 0;
    int errors = 0;
    int i0;
    logic [31:0] rd0, rd1;
    logic [1:0] cq[$];
    logic [1:0] gq[$];

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .bus_error(bus_error)
    );

    assign acc = s_read | s_write;
    assign idx = s_address[9:2];
    assign s_waitrequest = stall_force | (acc & ~ready_q);
    assign s_readdata = mem[idx];

    always @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | i;
        end else begin
            ready_q <= acc & ~ready_q;
            if (s_write && !s_waitrequest) mem[idx] <= s_writedata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int n0, input int n1);
        int d0 = 0;
        int d1 = 0;
        logic c0, c1, viol;
        viol = 1'b0;
        i0 = -1;
        cq.delete();
        gq.delete();
        for (int cyc = 0; cyc < 100 && (d0 < n0 || d1 < n1); cyc++) begin
            @(negedge clk);
            c0 = (m0_read || m0_write) && !m0_waitrequest;
            c1 = (m1_read || m1_write) && !m1_waitrequest;
            if ((grant != 2'b01 && !m0_waitrequest) || (grant != 2'b10 && !m1_waitrequest)) viol = 1'b1;
            gq.push_back(grant);
            if (c0) begin
                cq.push_back(grant);
                rd0 = m0_readdata;
                d0++;
                if (i0 < 0) i0 = cyc;
            end
            if (c1) begin
                cq.push_back(grant);
                rd1 = m1_readdata;
                d1++;
            end
            @(posedge clk);
            #1;
            if (c0 && d0 >= n0) begin m0_read = 1'b0; m0_write = 1'b0; end
            if (c1 && d1 >= n1) begin m1_read = 1'b0; m1_write = 1'b0; end
        end
        chk("serve_done", {d0[15:0], d1[15:0]}, {n0[15:0], n1[15:0]});
        chk("nonowner_wait", {31'd0, viol}, 32'd0);
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        m0_read = 1'b1;
        m1_read = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_s_read", {31'd0, s_read}, 32'd0);
        chk("rst_s_be", {28'd0, s_byteenable}, 32'd0);
        chk("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        chk("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        chk("rst_err", {31'd0, bus_error}, 32'd0);
        reset = 1'b0;
        m0_read = 1'b0;
        m1_read = 1'b0;
        repeat (2) @(negedge clk);

        m0_address = BASE;
        m0_read = 1'b1;
        @(negedge clk);
        chk("t2_grant", {30'd0, grant}, 32'd1);
        chk("t2_s_addr", s_address, BASE);
        chk("t2_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        serve(1, 0);
        chk("t2_rdata", rd0, 32'hC0DE0000);

        m1_address = BASE + 32'h4;
        m1_read = 1'b1;
        serve(0, 1);
        chk("m1_rdata", rd1, 32'hC0DE0001);

        m0_address = BASE;
        m0_read = 1'b1;
        m1_address = BASE + 32'h10;
        m1_writedata = 32'hDEADBEEF;
        m1_write = 1'b1;
        serve(1, 1);
        chk("t3_first", {30'd0, cq[0]}, 32'd1);
        chk("t3_second", {30'd0, cq[1]}, 32'd2);
        chk("t3_no_gap", {30'd0, gq[i0 + 1]}, 32'd2);
        chk("t3_rdata", rd0, 32'hC0DE0000);
        m1_read = 1'b1;
        serve(0, 1);
        chk("t3_readback", rd1, 32'hDEADBEEF);

        m0_address = BASE;
        m1_address = BASE + 32'h4;
        m0_read = 1'b1;
        m1_read = 1'b1;
        serve(4, 4);
        chk("t4_count", cq.size(), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t4_grant%0d", k), {30'd0, cq[k]}, (k % 2) ? 32'd2 : 32'd1);
        chk("t4_rd0", rd0, 32'hC0DE0000);
        chk("t4_rd1", rd1, 32'hC0DE0001);

        stall_force = 1'b1;
        m0_address = BASE + 32'h8;
        m0_read = 1'b1;
        @(negedge clk);
        chk("t5_grant", {30'd0, grant}, 32'd1);
        repeat (63) @(negedge clk);
        chk("t5_pre_err", {31'd0, bus_error}, 32'd0);
        chk("t5_pre_grant", {30'd0, grant}, 32'd1);
        @(negedge clk);
        chk("t5_err", {31'd0, bus_error}, 32'd1);
        chk("t5_idle", {30'd0, grant}, 32'd0);
        chk("t5_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        m0_read = 1'b0;
        stall_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_sticky", {31'd0, bus_error}, 32'd1);

        m1_address = BASE + 32'h20;
        m1_writedata = 32'h12345678;
        m1_write = 1'b1;
        stall_force = 1'b1;
        @(negedge clk);
        chk("t6_grant", {30'd0, grant}, 32'd2);
        chk("t6_s_write", {31'd0, s_write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_write", {31'd0, s_write}, 32'd0);
        chk("t6_rst_grant", {30'd0, grant}, 32'd0);
        chk("t6_rst_err", {31'd0, bus_error}, 32'd0);
        chk("t6_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        reset = 1'b0;
        stall_force = 1'b0;
        serve(0, 1);
        m1_read = 1'b1;
        serve(0, 1);
        chk("t6_readback", rd1, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
